// File: rtl/jt89_pkg.sv
// Shared constants and the mixer-word to PCM conversion for the JT89 output path.
package jt89_pkg;

    localparam int JT89_SND_W   = 11;
    localparam int JT89_SND_MID = 1024;
    localparam int JT89_I2S_W   = 16;

    // Offset-binary mixer word to signed PCM; the 11-bit range fills the top of 16 bits.
    function automatic logic signed [JT89_I2S_W-1:0] snd2pcm(input logic [JT89_SND_W-1:0] snd);
        logic signed [JT89_I2S_W-1:0] ofs;
        ofs = $signed(JT89_I2S_W'(snd)) - $signed(JT89_I2S_W'(JT89_SND_MID));
        return ofs <<< (JT89_I2S_W - JT89_SND_W);
    endfunction

endpackage

// File: rtl/jt89_i2s_tx_if.sv
// Mixer-side inputs and I2S pins of the JT89 serial transmitter.
interface jt89_i2s_tx_if;
    import jt89_pkg::*;

    logic                  cen;
    logic [JT89_SND_W-1:0] sound;
    logic                  bclk;
    logic                  lrck;
    logic                  sdata;
    logic                  sample_stb;

    modport master (
        output cen, sound,
        input  bclk, lrck, sdata, sample_stb
    );

    modport slave (
        input  cen, sound,
        output bclk, lrck, sdata, sample_stb
    );

endinterface

// File: rtl/jt89_bclk_div.sv
// Bit-clock divider: bclk toggles every DIV cen cycles; fall_o marks the 1->0 toggle cycle.
module jt89_bclk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    assign wrap = cen_i && (cnt_q == LAST);

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (wrap) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else if (cen_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // Combinational so the slot logic updates on the same edge that drops bclk.
    assign fall_o = wrap && bclk_q;

endmodule

// File: rtl/jt89_i2s_tx.sv
// Mono-duplicated I2S transmitter: captures the mixer word once per frame and
// shifts it out MSB first on both channels with the standard one-bit delay.
module jt89_i2s_tx
    import jt89_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    jt89_i2s_tx_if.slave bus
);

    logic                          fall;
    logic                          bclk;
    logic signed [JT89_I2S_W-1:0]  word;
    logic [4:0]                    slot_q, slot_d;
    logic                          lrck_q, lrck_d;
    logic                          sdata_q, sdata_d;
    logic                          stb_q, stb_d;
    logic [2*JT89_I2S_W-1:0]       frame_q, frame_d;

    jt89_bclk_div #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .cen_i  (bus.cen),
        .bclk_o (bclk),
        .fall_o (fall)
    );

    assign word = snd2pcm(bus.sound);

    // frame_q[31] always holds the bit due on the next slot, so the right LSB
    // leaves on slot 0 while the new word is loaded behind it.
    always_comb begin
        slot_d  = slot_q;
        lrck_d  = lrck_q;
        sdata_d = sdata_q;
        frame_d = frame_q;
        stb_d   = 1'b0;
        if (fall) begin
            slot_d  = slot_q + 5'd1;
            lrck_d  = slot_d[4];
            sdata_d = frame_q[2*JT89_I2S_W-1];
            if (slot_q == 5'd31) begin
                frame_d = {word, word};
                stb_d   = 1'b1;
            end else begin
                frame_d = {frame_q[2*JT89_I2S_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
            stb_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            slot_q  <= slot_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            stb_q   <= stb_d;
            frame_q <= frame_d;
        end
    end

    assign bus.bclk       = bclk;
    assign bus.lrck       = lrck_q;
    assign bus.sdata      = sdata_q;
    assign bus.sample_stb = stb_q;

endmodule

// File: doc/jt89_i2s_tx.md
Name: jt89_i2s_tx

Overview:
Serial audio transmitter for the JT89 output path. It consumes the unsigned 11-bit mixed sound word and converts it to signed 16-bit two's complement. It then transmits the word as a mono-duplicated I2S stream (BCLK/LRCK/SDATA) to an external DAC or codec. The block sits directly downstream of the channel mixer at the top of the PSG output chain.

Parameters:
DIV, 4, number of cen-qualified clk cycles per BCLK half-period (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
cen  input  1  clock enable; all timing counters advance only when cen=1
sound  input  11  unsigned mixer output, offset binary, midpoint 1024
bclk  output  1  I2S bit clock
lrck  output  1  I2S word select (0=left, 1=right)
sdata  output  1  I2S serial data, MSB first
sample_stb  output  1  one-clk pulse when sound is captured

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values: bclk=0, lrck=0, sdata=0, sample_stb=0, divider=0, slot counter=0, frame shift register=0 (silence).
- Divider: counts cen cycles 0..DIV-1. On the cen cycle where the count equals DIV-1, the divider wraps to 0 and bclk toggles. There is no advance while cen=0.
- Slot counter: 5 bits, 0..31. Increments on every bclk falling toggle (1->0) and wraps 31->0.
- lrck is registered, updates on the falling toggle: 0 during slots 0..15, 1 during slots 16..31.
- Conversion: word = (sound - 1024) << 5, 16-bit signed.
  - sound=0 gives 0x8000; sound=1024 gives 0x0000; sound=2047 gives 0x7FE0.
  - No saturation is needed.
- Capture: on the falling toggle entering slot 0, the converted word is loaded into the 32-bit frame register as {word, word}, left then right. sample_stb=1 for that single clk cycle. sound is sampled only at that instant; changes mid-frame are ignored.
- Serialisation uses the I2S one-bit delay. During slot s, sdata = frame bit (s-1) mod 32, where frame bit 0 is the left MSB. Consequently:
  - slot 0 carries the LSB of the previous frame's right word;
  - slot 1 carries the new left MSB;
  - slot 17 carries the right MSB.
- sdata and lrck change only on bclk falling toggles. Both are stable across the rising edge.
- Frame period is 64*DIV cen cycles: 256 clk with DIV=4 and cen tied high.
- cen gaps stretch timing uniformly, and no bits are dropped.
- Reset mid-frame returns everything to reset values immediately. The first post-reset capture occurs at the first falling toggle after the first complete 32-slot cycle. Until then sdata outputs zeros (silence).
- Combinational in-to-out paths: none. All outputs are registered.

Decomposition:
- Shared package jt89_pkg holds:
  - constant JT89_SND_W=11;
  - constant JT89_SND_MID=1024;
  - constant JT89_I2S_W=16;
  - the conversion function snd2pcm (offset-binary to signed with left shift).
- One natural sub-module: jt89_bclk_div, the DIV counter producing bclk plus rise/fall enable pulses. The remaining slot counter, frame register and strobe stay in jt89_i2s_tx.

Test Plan:
- Reset release, DIV=4, cen=1, sound=1024:
  - bclk period is 8 clk and the lrck period is 256 clk;
  - sample_stb pulses once per 256 clk;
  - captured left and right words both decode to 0x0000.
- sound=0 held: the decoded left and right words are 0x8000. The MSB appears at slot 1 and slot 17 (one bclk after each lrck edge).
- sound=1536 applied one clk before a sample_stb and changed to 512 mid-frame: that frame decodes 0x4000 for both channels. The next frame decodes 0xC000.
- cen toggling 1/0 every clk, DIV=2: bclk period is 8 clk and the frame is 256 clk. The decoded word matches the cen=1 case bit-exactly.
- rst asserted at slot 20 of a frame carrying 0x7FE0:
  - the next clk shows bclk=0, lrck=0, sdata=0, sample_stb=0;
  - after release, slots 1..31 of the first 32-slot cycle are all zero;
  - the following frame carries the new sample.
- DIV=1, cen=1: bclk toggles every clk. The frame is 64 clk, and a slot 0 sdata bit equals the previous right LSB (bit 0 of 0x7FE0 = 0; of 0x0020 = 0; verify with sound=1025 giving LSB 0 and bit 5 = 1).
